io_rx_port: RTL
===============

# io_rx_port

Receive-side I/O port for the j2 SoC. It drains bytes from the `buart` receiver into a small FIFO and answers CPU I/O reads with data or status on `io_data_in`. It is the read-direction counterpart to the existing write path, where CPU I/O writes drive UART transmit and the LEDs. It sits between `buart` (rx_data/valid/rd) and the `j2` core's I/O read bus.

## Interface
- `WIDTH`, `` `WIDTH`` (32): CPU data width.
- `DEPTH`, 16: FIFO depth in bytes. Must be a power of two, 2..128.
- `DATA_ADDR`, 16'h0000: I/O address that returns the head byte and pops it.
- `STATUS_ADDR`, 16'h0002: I/O address that returns the status word.

- `clock` in 1: single clock for everything.
- `active_low_reset` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: `buart` has a received byte; held until acknowledged.
- `rx_data` in 8: received byte.
- `rx_rd` out 1: registered one-cycle acknowledge to `buart`.
- `tx_busy` in 1: `buart` transmitter busy; reported in status only.
- `io_read_enable` in 1: CPU I/O read strobe, one cycle.
- `memory_address` in 16: CPU I/O address, valid with the strobe.
- `io_data_in` out WIDTH: registered read data to the core.
- `overflow` out 1: sticky flag, set when a byte is dropped.

## Operation
- Reset values: `rx_rd`=0, `io_data_in`=0, `overflow`=0. FIFO pointers and count = 0.
- **Capture:** on an edge where `rx_valid`=1 and `rx_rd`=0:
  - `rx_rd`<=1 for exactly one cycle.
  - If there is space, push `rx_data`.
  - If there is no space, drop the byte and set `overflow`<=1.
  - The capture condition includes `rx_rd`=0 so the still-high `rx_valid` is not captured twice.
- **Space rule:** space exists when count<DEPTH, or when a pop occurs on the same edge. A push to a full FIFO with a simultaneous pop is accepted.
- **Read DATA_ADDR**, on an edge where `io_read_enable`=1 and the address matches:
  - `io_data_in`<= zero-extended head byte, and the head is popped.
  - If the FIFO is empty: `io_data_in`<=0, no pop, count stays 0.
- **Read STATUS_ADDR:** `io_data_in`<= status word, then `overflow`<=0 on the same edge. If a drop happens on that same edge, set wins and `overflow` stays 1.
- **Status word:**
  - [7:0] count, zero-extended
  - [8] nonempty
  - [9] full
  - [10] overflow, value before the clear
  - [11] `tx_busy`
  - all other bits 0
- **Other addresses:** a read of any other address drives `io_data_in`<=0.
- **No strobe:** without `io_read_enable`, `io_data_in` holds its value.
- **Simultaneous push and pop:** count unchanged. The pop returns the old head. A push into an empty FIFO is not visible to a DATA read on the same edge; that read returns 0.
- **Wrap-around:** pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- **Reset mid-operation:** asserting reset immediately clears the FIFO, `overflow`, `rx_rd` and `io_data_in`. A byte pending in `buart` is captured after reset is released.

## Timing
- Read latency: 1 cycle. `io_data_in` is valid the cycle after the `io_read_enable` edge.
- `rx_rd` goes high the cycle after `rx_valid` is sampled and stays high for one cycle.
- Maximum capture rate: one byte per 2 cycles. This is far above the UART line rate.
- Status reflects the state before the edge on which the read is sampled.
- No combinational path from any input to any output.

## Structure
- Shared package/header `common.h`:
  - `` `WIDTH``
  - I/O address constants `IO_UART_DATA` and `IO_UART_STATUS`
  - status bit-index defines `ST_NONEMPTY`, `ST_FULL`, `ST_OVERFLOW`, `ST_TXBUSY`
- One sub-module, `sync_fifo_byte`: synchronous 8-bit FIFO with push, pop, full, empty and count, parameterized by DEPTH.
- Top-level logic: capture handshake, address decode, status assembly and output register.

## Test plan
- **Single byte:** drive `rx_valid`=1 with `rx_data`=8'h41, drop it after `rx_rd`.
  - -> exactly one `rx_rd` pulse.
  - -> STATUS read returns 32'h0000_0101.
  - -> DATA read returns 32'h0000_0041.
  - -> a second STATUS read returns 0.
- **Fill and overflow** (DEPTH=16): push bytes 0x00..0x10.
  - -> 17 `rx_rd` pulses.
  - -> STATUS = 32'h0000_0710 (count 16, nonempty, full, overflow).
  - -> after that read `overflow`=0.
  - -> DATA reads return 0x00..0x0F in order.
- **Empty read:** DATA read with the FIFO empty -> returns 0, count stays 0, no underflow.
- **Simultaneous events:** FIFO full, push 0xAA on the same edge as a DATA pop.
  - -> pop returns the old head.
  - -> count stays 16, `overflow` stays 0.
  - -> 0xAA is the last byte read out.
- **Wrap-around:** 40 interleaved push/pop pairs with bytes 0..39.
  - -> all bytes read back in order.
  - -> count ends at 0.
- **Mid-operation reset:** assert `active_low_reset` with 5 bytes queued and `overflow`=1.
  - -> `io_data_in`, `rx_rd` and `overflow` are 0 immediately.
  - -> after release, STATUS reads 32'h0000_0000, or 32'h0000_0800 if `tx_busy`=1.

Source files
------------

// File: rtl/io_rx_port_pkg.sv
// rtl/io_rx_port_pkg.sv - shared widths, I/O addresses and status layout for io_rx_port
package io_rx_port_pkg;

  localparam int CPU_WIDTH = 32;

  localparam logic [15:0] IO_UART_DATA   = 16'h0000;
  localparam logic [15:0] IO_UART_STATUS = 16'h0002;

  localparam int ST_NONEMPTY = 8;
  localparam int ST_FULL     = 9;
  localparam int ST_OVERFLOW = 10;
  localparam int ST_TXBUSY   = 11;

  function automatic logic [CPU_WIDTH-1:0] status_word(
    input logic [7:0] count,
    input logic       nonempty,
    input logic       full,
    input logic       ovf,
    input logic       busy
  );
    logic [CPU_WIDTH-1:0] w;
    w              = '0;
    w[7:0]         = count;
    w[ST_NONEMPTY] = nonempty;
    w[ST_FULL]     = full;
    w[ST_OVERFLOW] = ovf;
    w[ST_TXBUSY]   = busy;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo_byte.sv
// rtl/sync_fifo_byte.sv - synchronous byte FIFO with push, pop, full, empty and count
module sync_fifo_byte #(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   active_low_reset,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot a full-FIFO push needs.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/io_rx_port.sv
// rtl/io_rx_port.sv - buart receive FIFO answering CPU I/O reads with data or status
module io_rx_port
  import io_rx_port_pkg::*;
#(
  parameter int          WIDTH       = CPU_WIDTH,
  parameter int          DEPTH       = 16,
  parameter logic [15:0] DATA_ADDR   = IO_UART_DATA,
  parameter logic [15:0] STATUS_ADDR = IO_UART_STATUS
) (
  input  logic             clock,
  input  logic             active_low_reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_rd,
  input  logic             tx_busy,
  input  logic             io_read_enable,
  input  logic [15:0]      memory_address,
  output logic [WIDTH-1:0] io_data_in,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] count;
  logic [7:0]  head;
  logic        full;
  logic        empty;
  logic        capture;
  logic        rd_data;
  logic        rd_status;
  logic        pop;
  logic        push;
  logic        drop;

  // rx_rd gates capture so the still-asserted rx_valid is not taken twice.
  always_comb begin
    capture   = rx_valid & ~rx_rd;
    rd_data   = io_read_enable && (memory_address == DATA_ADDR);
    rd_status = io_read_enable && (memory_address == STATUS_ADDR);
    pop       = rd_data & ~empty;
    push      = capture & (~full | pop);
    drop      = capture & full & ~pop;
  end

  sync_fifo_byte #(.DEPTH(DEPTH)) u_fifo (
    .clock            (clock),
    .active_low_reset (active_low_reset),
    .push             (push),
    .push_data        (rx_data),
    .pop              (pop),
    .head             (head),
    .full             (full),
    .empty            (empty),
    .count            (count)
  );

  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      rx_rd      <= 1'b0;
      io_data_in <= '0;
      overflow   <= 1'b0;
    end else begin
      rx_rd <= capture;
      if (drop)           overflow <= 1'b1;
      else if (rd_status) overflow <= 1'b0;
      if (io_read_enable) begin
        if (rd_data)
          io_data_in <= empty ? '0 : WIDTH'(head);
        else if (rd_status)
          io_data_in <= WIDTH'(status_word(8'(count), ~empty, full, overflow, tx_busy));
        else
          io_data_in <= '0;
      end
    end
  end

endmodule
